// File: rtl/sd_pkg.sv
// Shared definitions for the SD command-line engine: frame lengths, CRC7 step and FSM states.
package sd_pkg;

    localparam int         CMD_LEN   = 48;
    localparam int         R2_LEN    = 136;
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RX,
        ST_TX,
        ST_TXEND
    } state_e;

    // One MSB-first step of CRC7 (x^7 + x^3 + 1).
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator with synchronous clear and bit enable.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = crc7_step(crc_q, bit_i);
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sdcmd.sv
// Card-side SD CMD-line engine: receives and CRC-checks host commands, serialises R1/R3/R2 replies.
// Define SDCMD_DS_EN to drive sd_ds as an enhanced data strobe while reply bits are on the line.
module sdcmd
    import sd_pkg::*;
(
    input  logic         sd_clk,
    input  logic         rst,
    inout  wire          sd_cmd,
    output logic         sd_ds,
    output logic         o_cmd_valid,
    output logic [5:0]   o_cmd,
    output logic [31:0]  o_arg,
    output logic         o_crc_err,
    input  logic         i_valid,
    input  logic         i_type,
    output logic         o_busy,
    input  logic [5:0]   i_reply,
    input  logic [119:0] i_arg,
    input  logic         i_use_crc,
    input  logic         i_drive,
    output logic         o_collision
);

    localparam logic [7:0] RX_LAST  = 8'(CMD_LEN - 1);
    localparam logic [7:0] CRC_SPAN = 8'(CMD_LEN - 8);
    localparam logic [7:0] LEN_R1   = 8'(CMD_LEN);
    localparam logic [7:0] LEN_R2   = 8'(R2_LEN);

    state_e       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [45:0]  rx_q, rx_d;
    logic [127:0] tx_sr_q, tx_sr_d;
    logic         type_q, type_d, use_crc_q, use_crc_d, drive_q, drive_d;
    logic         tx_on_q, tx_on_d, tx_bit_q, tx_bit_d;
    logic         coll_q, coll_d, valid_q, valid_d, crc_err_q, crc_err_d;
    logic [5:0]   cmd_q, cmd_d;
    logic [31:0]  arg_q, arg_d;
    logic         rx_crc_en, tx_crc_en;
    logic [6:0]   rx_crc, tx_crc;
    logic [7:0]   tx_len;
    logic         line;

    assign line   = sd_cmd;
    assign tx_len = type_q ? LEN_R2 : LEN_R1;

    sd_crc7 u_rx_crc (
        .clk_i (sd_clk),
        .rst_i (rst),
        .clr_i (state_q != ST_RX),
        .en_i  (rx_crc_en),
        .bit_i (line),
        .crc_o (rx_crc)
    );

    sd_crc7 u_tx_crc (
        .clk_i (sd_clk),
        .rst_i (rst),
        .clr_i (state_q != ST_TX),
        .en_i  (tx_crc_en),
        .bit_i (tx_sr_q[127]),
        .crc_o (tx_crc)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_sr_d   = tx_sr_q;
        type_d    = type_q;
        use_crc_d = use_crc_q;
        drive_d   = drive_q;
        tx_on_d   = 1'b0;
        tx_bit_d  = tx_bit_q;
        coll_d    = coll_q;
        valid_d   = 1'b0;
        crc_err_d = crc_err_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        rx_crc_en = 1'b0;
        tx_crc_en = 1'b0;

        if (tx_on_q && !drive_q && tx_bit_q && !line) begin
            coll_d = 1'b1;
        end

        unique case (state_q)
            // Acceptance is blocked through the end-bit cycle, which alone keeps N_CR >= 2.
            ST_IDLE: begin
                if (i_valid) begin
                    state_d   = ST_TX;
                    cnt_d     = '0;
                    type_d    = i_type;
                    use_crc_d = i_use_crc;
                    drive_d   = i_drive;
                    coll_d    = 1'b0;
                    tx_sr_d   = i_type ? {2'b00, 6'h3F, i_arg}
                                       : {2'b00, i_reply, i_arg[31:0], 88'h0};
                end else if (!line) begin
                    state_d = ST_RX;
                    cnt_d   = 8'd1;
                end
            end
            ST_RX: begin
                rx_crc_en = (cnt_q < CRC_SPAN);
                if (cnt_q == RX_LAST) begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b1;
                    cmd_d     = rx_q[44:39];
                    arg_d     = rx_q[38:7];
                    crc_err_d = (rx_q[6:0] != rx_crc) || !line || !rx_q[45];
                end else begin
                    rx_d  = {rx_q[44:0], line};
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_TX: begin
                if (cnt_q == tx_len) begin
                    state_d = ST_TXEND;
                end else begin
                    tx_on_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q == tx_len - 8'd8) begin
                        // Swap the finished CRC (or the R3 all-ones field) and end bit into the shifter.
                        tx_bit_d = use_crc_q ? tx_crc[6] : 1'b1;
                        tx_sr_d  = {(use_crc_q ? tx_crc[5:0] : 6'h3F), 1'b1, 121'h0};
                    end else begin
                        tx_bit_d  = tx_sr_q[127];
                        tx_sr_d   = {tx_sr_q[126:0], 1'b0};
                        tx_crc_en = (cnt_q < tx_len - 8'd8) && (!type_q || cnt_q >= 8'd8);
                    end
                end
            end
            ST_TXEND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            type_q    <= 1'b0;
            use_crc_q <= 1'b0;
            drive_q   <= 1'b0;
            tx_on_q   <= 1'b0;
            tx_bit_q  <= 1'b1;
            coll_q    <= 1'b0;
            valid_q   <= 1'b0;
            crc_err_q <= 1'b0;
            cmd_q     <= '0;
            arg_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            use_crc_q <= use_crc_d;
            drive_q   <= drive_d;
            tx_on_q   <= tx_on_d;
            tx_bit_q  <= tx_bit_d;
            coll_q    <= coll_d;
            valid_q   <= valid_d;
            crc_err_q <= crc_err_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
        end
    end

    // NOTE: the shift registers carry no reset; each frame reloads them before any bit is used.
    always_ff @(posedge sd_clk) begin
        rx_q    <= rx_d;
        tx_sr_q <= tx_sr_d;
    end

    // Open-drain releases 1-bits; reset releases the line without waiting for the edge.
    assign sd_cmd = (!rst && tx_on_q && (drive_q || !tx_bit_q)) ? tx_bit_q : 1'bz;

`ifdef SDCMD_DS_EN
    assign sd_ds = !rst && tx_on_q && sd_clk;
`else
    assign sd_ds = 1'b0;
`endif

    assign o_busy      = (state_q == ST_TX) || (state_q == ST_TXEND);
    assign o_cmd_valid = valid_q;
    assign o_cmd       = cmd_q;
    assign o_arg       = arg_q;
    assign o_crc_err   = crc_err_q;
    assign o_collision = coll_q;

endmodule

// File: tb/tb_sdcmd.sv
// Self-checking bench for sdcmd: host command frames via a scoreboard, reply framing, collision and reset.
module tb_sdcmd;

    typedef struct packed {
        logic [5:0]  cmd;
        logic [31:0] arg;
        logic        err;
    } exp_cmd_t;

    logic         sd_clk = 1'b0;
    logic         rst;
    wire          sd_cmd;
    logic         sd_ds;
    logic         o_cmd_valid;
    logic [5:0]   o_cmd;
    logic [31:0]  o_arg;
    logic         o_crc_err;
    logic         i_valid;
    logic         i_type;
    logic         o_busy;
    logic [5:0]   i_reply;
    logic [119:0] i_arg;
    logic         i_use_crc;
    logic         i_drive;
    logic         o_collision;

    logic host_en;
    logic host_val;
    int   vectors     = 0;
    int   miscompares = 0;
    exp_cmd_t exp_q[$];

    assign sd_cmd = host_en ? host_val : 1'bz;
    pullup (sd_cmd);

    always #5 sd_clk = ~sd_clk;

    sdcmd dut (
        .sd_clk      (sd_clk),
        .rst         (rst),
        .sd_cmd      (sd_cmd),
        .sd_ds       (sd_ds),
        .o_cmd_valid (o_cmd_valid),
        .o_cmd       (o_cmd),
        .o_arg       (o_arg),
        .o_crc_err   (o_crc_err),
        .i_valid     (i_valid),
        .i_type      (i_type),
        .o_busy      (o_busy),
        .i_reply     (i_reply),
        .i_arg       (i_arg),
        .i_use_crc   (i_use_crc),
        .i_drive     (i_drive),
        .o_collision (o_collision)
    );

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC7 written as an explicit tap update rather than a polynomial XOR.
    function automatic logic [6:0] ref_crc7(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic       inv;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            inv = d[i] ^ c[6];
            c   = {c[5:3], c[2] ^ inv, c[1:0], inv};
        end
        return c;
    endfunction

    // Scoreboard consumer: every strobe must match the oldest expected command.
    always @(negedge sd_clk) begin
        if (o_cmd_valid) begin
            exp_cmd_t e;
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL cmd_unexpected: observed strobe cmd %0d, expected no strobe", o_cmd);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("cmd_index", 136'(o_cmd), 136'(e.cmd));
                check("cmd_arg", 136'(o_arg), 136'(e.arg));
                check("cmd_crc_err", 136'(o_crc_err), 136'(e.err));
            end
        end
    end

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            host_en  = 1'b1;
            host_val = f[i];
            @(posedge sd_clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(negedge sd_clk);
        check(tag, 136'(exp_q.size()), 136'd0);
    endtask

    task automatic do_reply(input string tag, input logic typ, input logic [5:0] idx,
                            input logic [119:0] arg, input logic use_crc, input logic drive,
                            input logic pull, input int len, input logic [135:0] exp_frame,
                            input int exp_busy);
        logic [135:0] got;
        int nbits, start_at, busy_cnt;
        i_valid   = 1'b1;
        i_type    = typ;
        i_reply   = idx;
        i_arg     = arg;
        i_use_crc = use_crc;
        i_drive   = drive;
        @(posedge sd_clk);
        #1;
        i_valid  = 1'b0;
        got      = '0;
        nbits    = 0;
        start_at = -1;
        busy_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge sd_clk);
            if (o_busy) busy_cnt++;
            else if (c > 0) break;
            if (start_at < 0 && sd_cmd === 1'b0) start_at = c;
            if (start_at >= 0 && nbits < len) begin
                got = {got[134:0], sd_cmd};
                nbits++;
            end
            if (pull && start_at >= 0 && c == start_at + 1) begin
                host_en  = 1'b1;
                host_val = 1'b0;
            end
            if (pull && start_at >= 0 && c == start_at + 2) begin
                @(posedge sd_clk);
                #1;
                host_en = 1'b0;
            end
        end
        check({tag, "_start"}, 136'(start_at), 136'd1);
        check({tag, "_nbits"}, 136'(nbits), 136'(len));
        check({tag, "_frame"}, got, exp_frame);
        check({tag, "_busy"}, 136'(busy_cnt), 136'(exp_busy));
        check({tag, "_released"}, 136'(sd_cmd), 136'd1);
    endtask

    initial begin
        logic [119:0] r2_arg;
        logic [135:0] r2_exp;

        rst       = 1'b1;
        host_en   = 1'b0;
        host_val  = 1'b1;
        i_valid   = 1'b0;
        i_type    = 1'b0;
        i_reply   = '0;
        i_arg     = '0;
        i_use_crc = 1'b1;
        i_drive   = 1'b1;
        repeat (3) @(posedge sd_clk);
        #1;
        rst = 1'b0;

        @(negedge sd_clk);
        check("rst_busy", 136'(o_busy), 136'd0);
        check("rst_valid", 136'(o_cmd_valid), 136'd0);
        check("rst_crc_err", 136'(o_crc_err), 136'd0);
        check("rst_collision", 136'(o_collision), 136'd0);
        check("rst_cmd", 136'(o_cmd), 136'd0);
        check("rst_arg", 136'(o_arg), 136'd0);
        check("rst_ds", 136'(sd_ds), 136'd0);
        check("rst_line", 136'(sd_cmd), 136'd1);

        // CMD0 and CMD8 back to back: second start bit follows the first end bit directly.
        @(posedge sd_clk);
        #1;
        exp_q.push_back({6'd0, 32'h0, 1'b0});
        send_frame(48'h400000000095);
        exp_q.push_back({6'd8, 32'h1AA, 1'b0});
        send_frame(48'h48000001AA87);
        host_en = 1'b0;
        @(negedge sd_clk);
        check("cmd8_latency", 136'(o_cmd_valid), 136'd1);
        @(negedge sd_clk);
        check("cmd8_one_cycle", 136'(o_cmd_valid), 136'd0);
        drain("drain_cmd0_cmd8");

        repeat (2) @(posedge sd_clk);
        #1;
        exp_q.push_back({6'd17, 32'h0, 1'b0});
        send_frame(48'h510000000055);
        host_en = 1'b0;
        drain("drain_cmd17");

        repeat (2) @(posedge sd_clk);
        #1;
        exp_q.push_back({6'd0, 32'h0, 1'b1});
        send_frame(48'h400000000097);
        host_en = 1'b0;
        drain("drain_bad_crc");

        repeat (3) @(posedge sd_clk);
        #1;
        do_reply("r1", 1'b0, 6'd17, 120'h900, 1'b1, 1'b1, 1'b0, 48,
                 136'h110000090067, 50);
        check("r1_collision", 136'(o_collision), 136'd0);

        @(posedge sd_clk);
        #1;
        do_reply("r3", 1'b0, 6'h3F, 120'h80FF8000, 1'b0, 1'b1, 1'b0, 48,
                 136'h3F80FF8000FF, 50);

        // R2 in open-drain; the host pulls the first released bit (index bit 2) low.
        @(posedge sd_clk);
        #1;
        r2_arg        = 120'h00112233445566778899AABBCCDDEE;
        r2_exp        = {2'b00, 6'h3F, r2_arg, ref_crc7(r2_arg, 120), 1'b1};
        r2_exp[133]   = 1'b0;
        do_reply("r2", 1'b1, 6'h05, r2_arg, 1'b1, 1'b0, 1'b1, 136, r2_exp, 138);
        check("r2_collision", 136'(o_collision), 136'd1);

        // Reset in the middle of a reply that is driving zeros.
        @(posedge sd_clk);
        #1;
        i_valid   = 1'b1;
        i_type    = 1'b0;
        i_reply   = 6'd0;
        i_arg     = '0;
        i_use_crc = 1'b1;
        i_drive   = 1'b1;
        @(posedge sd_clk);
        #1;
        i_valid = 1'b0;
        repeat (10) @(negedge sd_clk);
        check("mid_busy", 136'(o_busy), 136'd1);
        check("mid_line", 136'(sd_cmd), 136'd0);
        check("coll_cleared", 136'(o_collision), 136'd0);
        @(posedge sd_clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_line_release", 136'(sd_cmd), 136'd1);
        @(posedge sd_clk);
        #1;
        rst = 1'b0;
        @(negedge sd_clk);
        check("rst_mid_busy", 136'(o_busy), 136'd0);
        check("rst_mid_line", 136'(sd_cmd), 136'd1);

        @(posedge sd_clk);
        #1;
        exp_q.push_back({6'd17, 32'h0, 1'b0});
        send_frame(48'h510000000055);
        host_en = 1'b0;
        drain("drain_after_reset");

        repeat (4) @(negedge sd_clk);
        check("final_queue", 136'(exp_q.size()), 136'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdcmd.md
# sdcmd

Card-side SD command-line engine for the SD-card simulation model; it sits between the host's CMD wire and the card's protocol state machine. It deserialises and CRC-checks 48-bit host commands and presents them as a one-cycle strobe. It also serialises 48-bit or 136-bit card responses, with optional open-drain arbitration and collision detection.

## Interface
- No parameters.
- `sd_clk` input 1: SD clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sd_cmd` inout 1: CMD wire.
- `sd_ds` output 1: data strobe (see Configuration).
- `o_cmd_valid` output 1: one-cycle strobe, a command frame was received.
- `o_cmd` output 6: command index.
- `o_arg` output 32: command argument.
- `o_crc_err` output 1: CRC7 or end-bit error, qualified by `o_cmd_valid`.
- `i_valid` input 1: reply request.
- `i_type` input 1: 0 selects a 48-bit reply, 1 selects a 136-bit R2 reply.
- `o_busy` output 1: reply engine occupied.
- `i_reply` input 6: reply index field (type 0 only).
- `i_arg` input 120: reply payload; type 0 uses `[31:0]`.
- `i_use_crc` input 1: 0 replaces the CRC7 field with 7'h7F (R3).
- `i_drive` input 1: 1 selects push-pull; 0 selects open-drain, where 1-bits are released.
- `o_collision` output 1: sticky; line read 0 while this block released it.

## Operation
- **Receive state machine**
  - States: IDLE, RX, TX, TXEND.
  - IDLE: a sampled `sd_cmd`==0 while not transmitting starts a frame.
  - Shift 48 bits MSB-first: start 0, direction 1, index[5:0], arg[31:0], CRC7, end 1.
  - After bit 48: pulse `o_cmd_valid` for 1 cycle and update `o_cmd`/`o_arg`.
  - `o_crc_err` = (CRC mismatch) | (end bit≠1) | (direction bit≠1).
  - CRC7: polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
- **Reply acceptance**
  - Accept when `i_valid && !o_busy && !receiving`.
  - Latch `i_type`, `i_reply`, `i_arg`, `i_use_crc`, `i_drive`.
  - `o_busy` rises the cycle after acceptance.
- **Reply frames**
  - Type 0: 0, 0, `i_reply`, `i_arg[31:0]`, CRC7 over the first 40 bits, 1. 48 bits.
  - Type 1: 0, 0, 6'b111111, `i_arg[119:0]`, CRC7 over `i_arg` only, 1. 136 bits.
  - The type-1 index is always 111111, ignoring `i_reply`.
- **Line drive**
  - Push-pull: drive the bit value.
  - Open-drain: drive 0 for 0-bits, high-Z for 1-bits.
  - Between frames: high-Z.
- **Collision**
  - In open-drain, a released bit sampled as 0 sets `o_collision`.
  - `o_collision` clears on the next reply acceptance or on reset.
  - The frame continues transmitting after a collision.
- **Reset**
  - Receiver to IDLE; line high-Z.
  - All outputs 0: `o_busy`, `o_cmd_valid`, `o_crc_err`, `o_collision`, `o_cmd`, `o_arg`, `sd_ds`.
  - Reset mid-frame discards the frame with no strobe.
  - Reset mid-reply releases the line immediately.

## Timing
- `o_cmd_valid` asserts 1 cycle after the end bit is sampled.
- Reply start bit: driven no earlier than 2 cycles after the command end bit (N_CR ≥ 2).
  - If `i_valid` arrives earlier, the start bit waits.
  - Otherwise it is driven 1 cycle after acceptance.
- One bit per `sd_clk` cycle; outputs change after the rising edge.
- `o_busy` stays high through the end bit, then 1 more cycle.
- `o_busy` falls 50 cycles after acceptance for type 0, 138 cycles for type 1, absent N_CR stall.
- A host start bit during TX is ignored.
- Back-to-back commands: a start bit sampled the cycle after an end bit is accepted.

## Configuration
- `SDCMD_DS_EN` defined: `sd_ds` follows `sd_clk` while a reply bit is driven and is 0 otherwise (HS400 enhanced strobe).
- `SDCMD_DS_EN` undefined: `sd_ds` is tied 0; no strobe logic.

## Structure
- Shared package `sd_pkg`:
  - frame lengths: CMD_LEN=48, R2_LEN=136;
  - CRC7 polynomial 7'h09;
  - function `crc7_step(crc, bit)`;
  - state enum.
- One sub-module, `sd_crc7`: serial CRC7 with clear and enable.
- Receive and transmit paths each instantiate one `sd_crc7`.

## Test plan
- Command frames, each checked for `o_cmd_valid` and `o_crc_err`=0:
  - frame 0x400000000095 → CMD0, arg 0;
  - frame 0x48000001AA87 → CMD8, arg 0x1AA;
  - frame 0x510000000055 → CMD17, arg 0.
- Frame 0x400000000097 (bad CRC) → `o_cmd_valid`=1, `o_crc_err`=1.
- Reply type 0: `i_reply`=17, `i_arg`=0x900, `i_use_crc`=1, `i_drive`=1 → line carries 0x110000090067.
  - `o_busy` high 50 cycles.
- Reply type 0 with `i_use_crc`=0: `i_reply`=0x3F, `i_arg`=0x80FF8000 → line carries 0x3F80FF8000FF.
- Reply type 1 (`i_drive`=0), bench pulls line to 0 on the first released bit → `o_collision`=1; frame still 136 bits.
- Reset asserted mid-reply → line high-Z, `o_busy`=0 next cycle, next command received normally.
